term_dequantizer: RTL

- Decoder for the term-quantized stream: consumes a stream of signed power-of-two terms (exponent + sign + valid/last) and reconstructs one signed fixed-point value per group.
- Enforces the per-group term budget: only the first MAX_TERMS terms of a group contribute; later terms are counted as dropped.
- Sits downstream of the term quantizer pipeline, feeding reconstructed values to the accumulate/compare datapath over a valid/ready interface.

---
 rtl/term_dequantizer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/term_dequantizer.sv
// Rebuilds one signed fixed-point value per group from a stream of signed power-of-two terms.
// Only the first MAX_TERMS terms of a group are summed; the rest are counted as dropped.
module term_dequantizer #(
   parameter int EXP_W     = 3,
   parameter int MAX_TERMS = 4,
   parameter int OUT_W     = 12,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EXP_W-1:0] in_exp,
   input  logic             in_sign,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_value,
   output logic [CNT_W-1:0] out_terms,
   output logic [CNT_W-1:0] out_dropped,
   output logic             out_sat
);

   // Wide enough for the accumulator plus the largest term without wrapping.
   localparam int MAG_W = (1 << EXP_W) + 1;
   localparam int SUM_W = ((OUT_W + 1 > MAG_W) ? OUT_W + 1 : MAG_W) + 1;

   localparam logic signed [SUM_W-1:0] MAX_V = (SUM_W'(1) << (OUT_W - 1)) - SUM_W'(1);
   localparam logic signed [SUM_W-1:0] MIN_V = -(SUM_W'(1) << (OUT_W - 1));
   localparam logic [CNT_W-1:0]        MAX_T = CNT_W'(MAX_TERMS);

   logic signed [OUT_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        term_cnt_q, term_cnt_d;
   logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
   logic                    acc_sat_q, acc_sat_d;
   logic                    out_valid_q, out_valid_d;
   logic [OUT_W-1:0]        out_value_q, out_value_d;
   logic [CNT_W-1:0]        out_terms_q, out_terms_d;
   logic [CNT_W-1:0]        out_dropped_q, out_dropped_d;
   logic                    out_sat_q, out_sat_d;

   logic                    accept;
   logic                    within_budget;
   logic signed [SUM_W-1:0] term_mag;
   logic signed [SUM_W-1:0] term_val;
   logic signed [SUM_W-1:0] acc_ext;
   logic signed [SUM_W-1:0] sum_full;
   logic signed [OUT_W-1:0] acc_upd;
   logic                    sat_upd;
   logic [CNT_W-1:0]        term_upd;
   logic [CNT_W-1:0]        drop_upd;

   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Candidate state after absorbing the presented term.
   always_comb begin
      within_budget = (term_cnt_q < MAX_T);
      term_mag      = SUM_W'(1) << in_exp;
      term_val      = in_sign ? -term_mag : term_mag;
      acc_ext       = {{(SUM_W - OUT_W){acc_q[OUT_W-1]}}, acc_q};
      sum_full      = acc_ext + term_val;
      acc_upd       = acc_q;
      sat_upd       = acc_sat_q;
      term_upd      = term_cnt_q;
      drop_upd      = drop_cnt_q;
      if (within_budget) begin
         term_upd = term_cnt_q + CNT_W'(1);
         if (sum_full > MAX_V) begin
            acc_upd = MAX_V[OUT_W-1:0];
            sat_upd = 1'b1;
         end else if (sum_full < MIN_V) begin
            acc_upd = MIN_V[OUT_W-1:0];
            sat_upd = 1'b1;
         end else begin
            acc_upd = sum_full[OUT_W-1:0];
         end
      end else if (!(&drop_cnt_q)) begin
         drop_upd = drop_cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      acc_d         = acc_q;
      term_cnt_d    = term_cnt_q;
      drop_cnt_d    = drop_cnt_q;
      acc_sat_d     = acc_sat_q;
      out_valid_d   = out_valid_q;
      out_value_d   = out_value_q;
      out_terms_d   = out_terms_q;
      out_dropped_d = out_dropped_q;
      out_sat_d     = out_sat_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (in_last) begin
            out_valid_d   = 1'b1;
            out_value_d   = acc_upd;
            out_terms_d   = term_upd;
            out_dropped_d = drop_upd;
            out_sat_d     = sat_upd;
            acc_d         = '0;
            term_cnt_d    = '0;
            drop_cnt_d    = '0;
            acc_sat_d     = 1'b0;
         end else begin
            acc_d      = acc_upd;
            term_cnt_d = term_upd;
            drop_cnt_d = drop_upd;
            acc_sat_d  = sat_upd;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         acc_q         <= '0;
         term_cnt_q    <= '0;
         drop_cnt_q    <= '0;
         acc_sat_q     <= 1'b0;
         out_valid_q   <= 1'b0;
         out_value_q   <= '0;
         out_terms_q   <= '0;
         out_dropped_q <= '0;
         out_sat_q     <= 1'b0;
      end else begin
         acc_q         <= acc_d;
         term_cnt_q    <= term_cnt_d;
         drop_cnt_q    <= drop_cnt_d;
         acc_sat_q     <= acc_sat_d;
         out_valid_q   <= out_valid_d;
         out_value_q   <= out_value_d;
         out_terms_q   <= out_terms_d;
         out_dropped_q <= out_dropped_d;
         out_sat_q     <= out_sat_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_value   = out_value_q;
   assign out_terms   = out_terms_q;
   assign out_dropped = out_dropped_q;
   assign out_sat     = out_sat_q;

endmodule
